// File: rtl/vga_vram_scheduler_pkg.sv
// vga_vram_scheduler_pkg
//   Shared constants and types for the text-mode VRAM port-B scheduler:
//   register addresses in the 12-bit CPU space, the FILL_CHR reset value
//   and the fill engine state encoding.
package vga_vram_scheduler_pkg;

  localparam logic [11:0] VRAM_BASE     = 12'h000;
  localparam logic [11:0] FILL_CHR_ADDR = 12'hF06;
  localparam logic [11:0] FILL_CTL_ADDR = 12'hF08;

  localparam logic [7:0]  FILL_CHR_INIT = 8'h20;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_e;

endpackage

// File: rtl/vga_vram_scheduler_fill.sv
// vram_fill_engine
//   Screen-fill engine: cell counter, fill FSM and FILL_CHR register.
//   Ports:
//     clock, reset_l   rising-edge clock, async active-low reset
//     slot_grant       port B is free for a fill write this cycle
//     chr_wr/chr_data  FILL_CHR register write
//     ctl_wr/ctl_start FILL_CTL write; ctl_start=1 starts/restarts, 0 aborts
//     fill_we          fill write requested this cycle (combinational)
//     fill_addr/data   address/character for that write
//     fill_busy        registered, high from start until FillDone
//     fill_done        registered one-cycle pulse after the LAST write
module vram_fill_engine
  import vga_vram_scheduler_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 40
) (
  input  logic        clock,
  input  logic        reset_l,
  input  logic        slot_grant,
  input  logic        chr_wr,
  input  logic [7:0]  chr_data,
  input  logic        ctl_wr,
  input  logic        ctl_start,
  output logic        fill_we,
  output logic [11:0] fill_addr,
  output logic [7:0]  fill_data,
  output logic        fill_busy,
  output logic        fill_done
);

  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

  fill_state_e state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  chr_q, chr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chr_d   = chr_wr ? chr_data : chr_q;
    fill_we = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (ctl_wr && ctl_start) begin
          state_d = FILL_RUN;
          cnt_d   = '0;
        end
      end
      FILL_RUN: begin
        // A control write owns the cycle: restart or abort, no fill write.
        if (ctl_wr) begin
          if (ctl_start) cnt_d = '0;
          else           state_d = FILL_IDLE;
        end else if (slot_grant) begin
          fill_we = 1'b1;
          if (cnt_q == LAST_ADDR) state_d = FILL_DONE;
          else                    cnt_d   = cnt_q + 12'd1;
        end
      end
      FILL_DONE: begin
        if (ctl_wr && ctl_start) begin
          state_d = FILL_RUN;
          cnt_d   = '0;
        end else begin
          state_d = FILL_IDLE;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
    // Busy covers DONE so it drops in the same cycle the done pulse appears,
    // one cycle after the LAST write becomes visible on port B.
    busy_d = (state_d != FILL_IDLE);
    done_d = (state_q == FILL_DONE);
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= FILL_IDLE;
      cnt_q   <= '0;
      chr_q   <= FILL_CHR_INIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chr_q   <= chr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fill_addr = cnt_q;
  assign fill_data = chr_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;

endmodule

// File: rtl/vga_vram_scheduler.sv
// vga_vram_scheduler
//   Shares VRAM write port B between CPU writes (fixed 1-cycle latency,
//   always priority) and the hardware screen-fill engine.
//   Decodes 0x000..LAST (VRAM), 0xF06 (FILL_CHR), 0xF08 (FILL_CTL).
//   Ports:
//     Clock, Reset_L         rising-edge clock, async active-low reset
//     CPU_Enable             write strobe; one access per rising edge
//     Address[11:0], Data    CPU address / write data
//     VBlank                 fill gate (only with VBLANK_GATE_EN)
//     RamAddrB/RamDataB/RamWeB  registered port-B write
//     CPU_Ack                one-cycle ack for decoded accesses
//     FillBusy, FillDone     fill status
//   Build option: `define VBLANK_GATE_EN restricts fill writes to VBlank=1.
module vga_vram_scheduler
  import vga_vram_scheduler_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 40
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        CPU_Enable,
  input  logic [11:0] Address,
  input  logic [7:0]  Data,
`ifdef VBLANK_GATE_EN
  input  logic        VBlank,
`endif
  output logic [11:0] RamAddrB,
  output logic [7:0]  RamDataB,
  output logic        RamWeB,
  output logic        CPU_Ack,
  output logic        FillBusy,
  output logic        FillDone
);

  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

  logic        en_q;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic        ram_we_q, ram_we_d;
  logic        ack_q, ack_d;

  logic        access;
  logic [11:0] vram_offset;
  logic        cpu_vram_wr, chr_wr, ctl_wr;
  logic        slot_grant;
  logic        fill_we;
  logic [11:0] fill_addr;
  logic [7:0]  fill_data;

  always_comb begin
    access      = CPU_Enable && !en_q;
    vram_offset = Address - VRAM_BASE;
    cpu_vram_wr = access && (vram_offset <= LAST_ADDR);
    chr_wr      = access && (Address == FILL_CHR_ADDR);
    ctl_wr      = access && (Address == FILL_CTL_ADDR);
`ifdef VBLANK_GATE_EN
    slot_grant  = !cpu_vram_wr && VBlank;
`else
    slot_grant  = !cpu_vram_wr;
`endif
    ack_d       = cpu_vram_wr || chr_wr || ctl_wr;
    ram_we_d    = cpu_vram_wr || fill_we;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    if (cpu_vram_wr) begin
      ram_addr_d = Address;
      ram_data_d = Data;
    end else if (fill_we) begin
      ram_addr_d = fill_addr;
      ram_data_d = fill_data;
    end
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      en_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      en_q       <= CPU_Enable;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      ack_q      <= ack_d;
    end
  end

  vram_fill_engine #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_fill (
    .clock      (Clock),
    .reset_l    (Reset_L),
    .slot_grant (slot_grant),
    .chr_wr     (chr_wr),
    .chr_data   (Data),
    .ctl_wr     (ctl_wr),
    .ctl_start  (Data[0]),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .fill_busy  (FillBusy),
    .fill_done  (FillDone)
  );

  assign RamAddrB = ram_addr_q;
  assign RamDataB = ram_data_q;
  assign RamWeB   = ram_we_q;
  assign CPU_Ack  = ack_q;

endmodule

// File: tb/tb_vga_vram_scheduler.sv
// Directed bench for vga_vram_scheduler (default 80x40, LAST=0xC7F).
module tb_vga_vram_scheduler;

  logic        Clock;
  logic        Reset_L;
  logic        CPU_Enable;
  logic [11:0] Address;
  logic [7:0]  Data;
  logic [11:0] RamAddrB;
  logic [7:0]  RamDataB;
  logic        RamWeB;
  logic        CPU_Ack;
  logic        FillBusy;
  logic        FillDone;
`ifdef VBLANK_GATE_EN
  logic        VBlank;
  initial VBlank = 1'b1;
`endif

  int passed = 0;
  int total  = 0;

  // {We, Ack, Busy, Done} and the full {We, Addr, Data, Ack, Busy, Done}.
  logic [3:0]  ctl_obs;
  logic [23:0] full_obs;
  assign ctl_obs  = {RamWeB, CPU_Ack, FillBusy, FillDone};
  assign full_obs = {RamWeB, RamAddrB, RamDataB, CPU_Ack, FillBusy, FillDone};

  vga_vram_scheduler #(
    .COLS (80),
    .ROWS (40)
  ) dut (
    .Clock      (Clock),
    .Reset_L    (Reset_L),
    .CPU_Enable (CPU_Enable),
    .Address    (Address),
    .Data       (Data),
`ifdef VBLANK_GATE_EN
    .VBlank     (VBlank),
`endif
    .RamAddrB   (RamAddrB),
    .RamDataB   (RamDataB),
    .RamWeB     (RamWeB),
    .CPU_Ack    (CPU_Ack),
    .FillBusy   (FillBusy),
    .FillDone   (FillDone)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // Raise the strobe for one cycle; on return outputs show cycle N+1.
  task automatic cpu_pulse(input logic [11:0] a, input logic [7:0] d);
    CPU_Enable = 1'b1;
    Address    = a;
    Data       = d;
    cyc();
    CPU_Enable = 1'b0;
  endtask

  task automatic test_reset();
    Reset_L    = 1'b0;
    CPU_Enable = 1'b0;
    Address    = '0;
    Data       = '0;
    repeat (2) cyc();
    total++;
    if (full_obs !== 24'h0) $display("FAIL reset_outputs got=%h exp=%h", full_obs, 24'h0);
    else passed++;
    Reset_L = 1'b1;
    cyc();
    total++;
    if (ctl_obs !== 4'b0000) $display("FAIL reset_release got=%b exp=%b", ctl_obs, 4'b0000);
    else passed++;
  endtask

  task automatic test_cpu_held();
    int extra;
    CPU_Enable = 1'b1;
    Address    = 12'h010;
    Data       = 8'h41;
    cyc();
    total++;
    if (full_obs !== {1'b1, 12'h010, 8'h41, 1'b1, 1'b0, 1'b0})
      $display("FAIL cpu_write got=%h exp=%h", full_obs, {1'b1, 12'h010, 8'h41, 3'b100});
    else passed++;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (RamWeB !== 1'b0 || CPU_Ack !== 1'b0) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL cpu_held_single got=%0d extra pulses exp=0", extra);
    else passed++;
    CPU_Enable = 1'b0;
    cyc();
  endtask

  task automatic test_full_fill();
    int bad;
    int first_bad;
    logic [23:0] bad_obs;
    cpu_pulse(12'hF06, 8'h2A);
    total++;
    if (ctl_obs !== 4'b0100) $display("FAIL chr_write got=%b exp=%b", ctl_obs, 4'b0100);
    else passed++;
    cyc();
    cpu_pulse(12'hF08, 8'h01);
    total++;
    if (ctl_obs !== 4'b0110) $display("FAIL start_ack got=%b exp=%b", ctl_obs, 4'b0110);
    else passed++;
    bad = 0;
    first_bad = -1;
    bad_obs = '0;
    for (int i = 0; i < 3200; i++) begin
      cyc();
      if (full_obs !== {1'b1, 12'(i), 8'h2A, 3'b010}) begin
        if (bad == 0) begin
          first_bad = i;
          bad_obs   = full_obs;
        end
        bad++;
      end
    end
    total++;
    if (bad !== 0)
      $display("FAIL fill_sweep got=%0d bad cells (first idx %0d obs=%h) exp=0", bad, first_bad, bad_obs);
    else passed++;
    cyc();
    total++;
    if (ctl_obs !== 4'b0001) $display("FAIL fill_done got=%b exp=%b", ctl_obs, 4'b0001);
    else passed++;
    cyc();
    total++;
    if (ctl_obs !== 4'b0000) $display("FAIL fill_done_one_cycle got=%b exp=%b", ctl_obs, 4'b0000);
    else passed++;
  endtask

  task automatic test_contention_and_abort();
    int bad;
    cpu_pulse(12'hF08, 8'h01);
    repeat (12'h080) cyc();
    total++;
    if (full_obs !== {1'b1, 12'h07F, 8'h2A, 3'b010})
      $display("FAIL pre_contention got=%h exp=%h", full_obs, {1'b1, 12'h07F, 8'h2A, 3'b010});
    else passed++;
    cpu_pulse(12'h100, 8'h55);
    total++;
    if (full_obs !== {1'b1, 12'h100, 8'h55, 3'b110})
      $display("FAIL cpu_wins got=%h exp=%h", full_obs, {1'b1, 12'h100, 8'h55, 3'b110});
    else passed++;
    cyc();
    total++;
    if (full_obs !== {1'b1, 12'h080, 8'h2A, 3'b010})
      $display("FAIL fill_resume got=%h exp=%h", full_obs, {1'b1, 12'h080, 8'h2A, 3'b010});
    else passed++;
    cyc();
    total++;
    if (full_obs !== {1'b1, 12'h081, 8'h2A, 3'b010})
      $display("FAIL fill_next got=%h exp=%h", full_obs, {1'b1, 12'h081, 8'h2A, 3'b010});
    else passed++;
    repeat (12'h17E) cyc();
    total++;
    if (full_obs !== {1'b1, 12'h1FF, 8'h2A, 3'b010})
      $display("FAIL pre_abort got=%h exp=%h", full_obs, {1'b1, 12'h1FF, 8'h2A, 3'b010});
    else passed++;
    cpu_pulse(12'hF08, 8'h00);
    total++;
    if (ctl_obs !== 4'b0100) $display("FAIL abort got=%b exp=%b", ctl_obs, 4'b0100);
    else passed++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ctl_obs !== 4'b0000) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL abort_quiet got=%0d active cycles exp=0", bad);
    else passed++;
  endtask

  task automatic test_ignored();
    cpu_pulse(12'hF02, 8'h10);
    total++;
    if (ctl_obs !== 4'b0000) $display("FAIL ignore_f02 got=%b exp=%b", ctl_obs, 4'b0000);
    else passed++;
    cyc();
    cpu_pulse(12'hD00, 8'h33);
    total++;
    if (ctl_obs !== 4'b0000) $display("FAIL ignore_d00 got=%b exp=%b", ctl_obs, 4'b0000);
    else passed++;
    cyc();
  endtask

  task automatic test_last_contention();
    cpu_pulse(12'hF08, 8'h01);
    repeat (12'hC7F) cyc();
    total++;
    if (full_obs !== {1'b1, 12'hC7E, 8'h2A, 3'b010})
      $display("FAIL pre_last got=%h exp=%h", full_obs, {1'b1, 12'hC7E, 8'h2A, 3'b010});
    else passed++;
    cpu_pulse(12'h005, 8'h77);
    total++;
    if (full_obs !== {1'b1, 12'h005, 8'h77, 3'b110})
      $display("FAIL last_cpu_first got=%h exp=%h", full_obs, {1'b1, 12'h005, 8'h77, 3'b110});
    else passed++;
    cyc();
    total++;
    if (full_obs !== {1'b1, 12'hC7F, 8'h2A, 3'b010})
      $display("FAIL last_fill got=%h exp=%h", full_obs, {1'b1, 12'hC7F, 8'h2A, 3'b010});
    else passed++;
    cyc();
    total++;
    if (ctl_obs !== 4'b0001) $display("FAIL last_done got=%b exp=%b", ctl_obs, 4'b0001);
    else passed++;
    cyc();
  endtask

  task automatic test_reset_mid_fill();
    cpu_pulse(12'hF08, 8'h01);
    repeat (10) cyc();
    total++;
    if (ctl_obs !== 4'b1010) $display("FAIL mid_fill_active got=%b exp=%b", ctl_obs, 4'b1010);
    else passed++;
    Reset_L = 1'b0;
    #1;
    total++;
    if (full_obs !== 24'h0) $display("FAIL async_reset got=%h exp=%h", full_obs, 24'h0);
    else passed++;
    cyc();
    Reset_L = 1'b1;
    repeat (3) cyc();
    total++;
    if (ctl_obs !== 4'b0000) $display("FAIL post_reset_idle got=%b exp=%b", ctl_obs, 4'b0000);
    else passed++;
    cpu_pulse(12'hF08, 8'h01);
    cyc();
    total++;
    if (full_obs !== {1'b1, 12'h000, 8'h20, 3'b010})
      $display("FAIL chr_reset_value got=%h exp=%h", full_obs, {1'b1, 12'h000, 8'h20, 3'b010});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_cpu_held();
    test_full_fill();
    test_contention_and_abort();
    test_ignored();
    test_last_contention();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
